// File: rtl/i_fetch_unit_pkg.sv
// Shared constants for the instruction fetch slice: data width, PC step,
// NOP encoding, the instruction memory reset image and default depth.
package i_fetch_unit_pkg;

    localparam int          DATA_W            = 32;
    localparam logic [31:0] PC_INC            = 32'd4;
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
    localparam int          DEFAULT_MEM_DEPTH = 256;

    localparam logic [31:0] RESET_WORD_0 = 32'h012D_B820;
    localparam logic [31:0] RESET_WORD_1 = 32'h5001_6BFF;
    localparam logic [31:0] RESET_WORD_2 = 32'h7006_0000;
    localparam logic [31:0] RESET_WORD_3 = 32'hA011_8D50;

    // Boot image: four program words at the bottom, NOP everywhere else.
    function automatic logic [DATA_W-1:0] reset_word(input int idx);
        case (idx)
            0:       return RESET_WORD_0;
            1:       return RESET_WORD_1;
            2:       return RESET_WORD_2;
            3:       return RESET_WORD_3;
            default: return NOP_INSTR;
        endcase
    endfunction

endpackage

// File: rtl/i_fetch_imem.sv
// Instruction memory: combinational read, contents loaded from the boot
// image while RST is low and otherwise read-only.
module i_fetch_imem
    import i_fetch_unit_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    localparam int AW       = $clog2(MEM_DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] MEM [MEM_DEPTH];

    // Reload the boot image during reset; storage holds its value otherwise.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                MEM[i] <= reset_word(i);
            end
        end
    end

    // Asynchronous read port.
    always_comb begin
        rd_data = MEM[rd_addr];
    end

endmodule

// File: rtl/i_fetch_unit.sv
// Instruction fetch stage: PC register, instruction memory and IF/ID
// pipeline register. Define I_FETCH_FLUSH_EN to turn a taken branch into a
// bubble (NOP, NPC=0) in IF/ID instead of capturing the wrong-path fetch.
module i_fetch_unit
    import i_fetch_unit_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BRANCH,
    input  logic              PC_WRITE,
    input  logic [DATA_W-1:0] EX_MEM_NPC,
    output logic [DATA_W-1:0] IF_ID_INSTR,
    output logic [DATA_W-1:0] IF_ID_NPC
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] fetch_instr;

    // Sequential PC successor; wraps naturally modulo 2^32.
    always_comb begin
        pc_plus4 = pc + PC_INC;
    end

    // Word index ignores byte offset and upper bits, so fetch wraps in memory.
    i_fetch_imem #(
        .MEM_DEPTH (MEM_DEPTH)
    ) instMem_1 (
        .CLK     (CLK),
        .RST     (RST),
        .rd_addr (pc[AW+1:2]),
        .rd_data (fetch_instr)
    );

    // PC update: a taken branch wins over a stall.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc <= '0;
        end else if (BRANCH) begin
            pc <= EX_MEM_NPC;
        end else if (PC_WRITE) begin
            pc <= pc_plus4;
        end
    end

    // IF/ID register: capture the fetch at the pre-edge PC, or bubble on branch.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            IF_ID_INSTR <= NOP_INSTR;
            IF_ID_NPC   <= '0;
        end else if (BRANCH) begin
`ifdef I_FETCH_FLUSH_EN
            IF_ID_INSTR <= NOP_INSTR;
            IF_ID_NPC   <= '0;
`else
            IF_ID_INSTR <= fetch_instr;
            IF_ID_NPC   <= pc_plus4;
`endif
        end else if (PC_WRITE) begin
            IF_ID_INSTR <= fetch_instr;
            IF_ID_NPC   <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_i_fetch_unit.sv
// Directed self-checking bench for i_fetch_unit. Expected values are
// hand-derived from the boot image; the branch cases adapt to whether
// I_FETCH_FLUSH_EN is defined for the build.
module tb_i_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        BRANCH;
    logic        PC_WRITE;
    logic [31:0] EX_MEM_NPC;
    logic [31:0] IF_ID_INSTR;
    logic [31:0] IF_ID_NPC;

    int checks   = 0;
    int failures = 0;

`ifdef I_FETCH_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    i_fetch_unit #(.MEM_DEPTH(256)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .BRANCH      (BRANCH),
        .PC_WRITE    (PC_WRITE),
        .EX_MEM_NPC  (EX_MEM_NPC),
        .IF_ID_INSTR (IF_ID_INSTR),
        .IF_ID_NPC   (IF_ID_NPC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] img [4];
        img[0] = 32'h012DB820; img[1] = 32'h50016BFF;
        img[2] = 32'h70060000; img[3] = 32'hA0118D50;
        RST = 1'b0; BRANCH = 1'b0; PC_WRITE = 1'b0; EX_MEM_NPC = '0;
        #10;
        checks++;
        if (IF_ID_INSTR !== 32'h0 || IF_ID_NPC !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got instr=%h npc=%h, want 00000000/00000000", IF_ID_INSTR, IF_ID_NPC);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.instMem_1.MEM[i] !== img[i]) begin
                failures++;
                $display("FAIL reset_mem[%0d]: got %h, want %h", i, dut.instMem_1.MEM[i], img[i]);
            end
        end
        checks++;
        if (dut.instMem_1.MEM[4] !== 32'h0 || dut.instMem_1.MEM[255] !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem_nop: got mem4=%h mem255=%h, want 0", dut.instMem_1.MEM[4], dut.instMem_1.MEM[255]);
        end
        // Release away from an edge.
        @(negedge CLK);
        RST = 1'b1;
    endtask

    // Sequential fetch with a two-edge stall after the first fetch.
    task automatic test_sequential();
        logic        pw  [5];
        logic [31:0] ei  [5];
        logic [31:0] en  [5];
        pw[0] = 1; ei[0] = 32'h012DB820; en[0] = 32'h4;
        pw[1] = 0; ei[1] = 32'h012DB820; en[1] = 32'h4;
        pw[2] = 0; ei[2] = 32'h012DB820; en[2] = 32'h4;
        pw[3] = 1; ei[3] = 32'h50016BFF; en[3] = 32'h8;
        pw[4] = 1; ei[4] = 32'h70060000; en[4] = 32'hC;
        for (int s = 0; s < 5; s++) begin
            PC_WRITE = pw[s];
            BRANCH   = 1'b0;
            tick();
            checks++;
            if (IF_ID_INSTR !== ei[s] || IF_ID_NPC !== en[s]) begin
                failures++;
                $display("FAIL seq_step%0d: got instr=%h npc=%h, want %h/%h", s, IF_ID_INSTR, IF_ID_NPC, ei[s], en[s]);
            end
        end
    endtask

    // Branch to 0xC with PC at 0xC, then a branch under stall (priority).
    task automatic test_branch();
        logic [31:0] ei, en;
        PC_WRITE = 1'b1; BRANCH = 1'b1; EX_MEM_NPC = 32'hC;
        tick();
        ei = FLUSH ? 32'h0 : 32'hA0118D50;
        en = FLUSH ? 32'h0 : 32'h10;
        checks++;
        if (IF_ID_INSTR !== ei || IF_ID_NPC !== en) begin
            failures++;
            $display("FAIL branch_edge: got instr=%h npc=%h, want %h/%h", IF_ID_INSTR, IF_ID_NPC, ei, en);
        end
        BRANCH = 1'b0;
        tick();
        checks++;
        if (IF_ID_INSTR !== 32'hA0118D50 || IF_ID_NPC !== 32'h10) begin
            failures++;
            $display("FAIL branch_target: got instr=%h npc=%h, want a0118d50/00000010", IF_ID_INSTR, IF_ID_NPC);
        end
        // PC=0x10 now; branch with PC_WRITE=0 must still redirect.
        PC_WRITE = 1'b0; BRANCH = 1'b1; EX_MEM_NPC = 32'h4;
        tick();
        ei = 32'h0;
        en = FLUSH ? 32'h0 : 32'h14;
        checks++;
        if (IF_ID_INSTR !== ei || IF_ID_NPC !== en) begin
            failures++;
            $display("FAIL branch_stall_edge: got instr=%h npc=%h, want %h/%h", IF_ID_INSTR, IF_ID_NPC, ei, en);
        end
        BRANCH = 1'b0; PC_WRITE = 1'b1;
        tick();
        checks++;
        if (IF_ID_INSTR !== 32'h50016BFF || IF_ID_NPC !== 32'h8) begin
            failures++;
            $display("FAIL branch_priority: got instr=%h npc=%h, want 50016bff/00000008", IF_ID_INSTR, IF_ID_NPC);
        end
    endtask

    // Advance to PC=0x10, then assert reset asynchronously between edges.
    task automatic test_reset_mid();
        BRANCH = 1'b0; PC_WRITE = 1'b1;
        tick();  // (70060000, C), PC=0xC
        tick();  // (A0118D50, 10), PC=0x10
        checks++;
        if (IF_ID_INSTR !== 32'hA0118D50 || IF_ID_NPC !== 32'h10) begin
            failures++;
            $display("FAIL pre_reset_state: got instr=%h npc=%h, want a0118d50/00000010", IF_ID_INSTR, IF_ID_NPC);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (IF_ID_INSTR !== 32'h0 || IF_ID_NPC !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: got instr=%h npc=%h, want 0/0", IF_ID_INSTR, IF_ID_NPC);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        tick();
        checks++;
        if (IF_ID_INSTR !== 32'h012DB820 || IF_ID_NPC !== 32'h4) begin
            failures++;
            $display("FAIL post_reset_fetch: got instr=%h npc=%h, want 012db820/00000004", IF_ID_INSTR, IF_ID_NPC);
        end
    endtask

    // Last memory word wraps fetch to word 0; PC itself keeps counting, so
    // NPC after 0x400 is 0x404. Then 0xFFFFFFFC wraps the full PC to 0.
    task automatic test_wrap();
        logic [31:0] ei, en;
        // PC=0x4 entering this test.
        PC_WRITE = 1'b1; BRANCH = 1'b1; EX_MEM_NPC = 32'h3FC;
        tick();
        ei = FLUSH ? 32'h0 : 32'h50016BFF;
        en = FLUSH ? 32'h0 : 32'h8;
        checks++;
        if (IF_ID_INSTR !== ei || IF_ID_NPC !== en) begin
            failures++;
            $display("FAIL wrap_branch_edge: got instr=%h npc=%h, want %h/%h", IF_ID_INSTR, IF_ID_NPC, ei, en);
        end
        BRANCH = 1'b0;
        tick();
        checks++;
        if (IF_ID_INSTR !== 32'h0 || IF_ID_NPC !== 32'h400) begin
            failures++;
            $display("FAIL wrap_last_word: got instr=%h npc=%h, want 00000000/00000400", IF_ID_INSTR, IF_ID_NPC);
        end
        tick();
        checks++;
        if (IF_ID_INSTR !== 32'h012DB820 || IF_ID_NPC !== 32'h404) begin
            failures++;
            $display("FAIL wrap_word0: got instr=%h npc=%h, want 012db820/00000404", IF_ID_INSTR, IF_ID_NPC);
        end
        BRANCH = 1'b1; EX_MEM_NPC = 32'hFFFF_FFFC;
        tick();
        BRANCH = 1'b0;
        tick();
        checks++;
        if (IF_ID_INSTR !== 32'h0 || IF_ID_NPC !== 32'h0) begin
            failures++;
            $display("FAIL pc32_wrap_top: got instr=%h npc=%h, want 0/0", IF_ID_INSTR, IF_ID_NPC);
        end
        tick();
        checks++;
        if (IF_ID_INSTR !== 32'h012DB820 || IF_ID_NPC !== 32'h4) begin
            failures++;
            $display("FAIL pc32_wrap_zero: got instr=%h npc=%h, want 012db820/00000004", IF_ID_INSTR, IF_ID_NPC);
        end
    endtask

    // Two consecutive taken branches; the second captures the first's target.
    task automatic test_back_to_back();
        logic [31:0] ei, en;
        PC_WRITE = 1'b1; BRANCH = 1'b1; EX_MEM_NPC = 32'h8;
        tick();
        EX_MEM_NPC = 32'h0;
        tick();
        ei = FLUSH ? 32'h0 : 32'h70060000;
        en = FLUSH ? 32'h0 : 32'hC;
        checks++;
        if (IF_ID_INSTR !== ei || IF_ID_NPC !== en) begin
            failures++;
            $display("FAIL b2b_second_branch: got instr=%h npc=%h, want %h/%h", IF_ID_INSTR, IF_ID_NPC, ei, en);
        end
        BRANCH = 1'b0;
        tick();
        checks++;
        if (IF_ID_INSTR !== 32'h012DB820 || IF_ID_NPC !== 32'h4) begin
            failures++;
            $display("FAIL b2b_target: got instr=%h npc=%h, want 012db820/00000004", IF_ID_INSTR, IF_ID_NPC);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
